// File: rtl/mac_pkg.sv
// Shared types and helpers for the streaming MAC accumulator family.
package mac_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } mac_state_e;

  localparam int MAC_PW    = 16;
  localparam int MAC_ACC_W = 24;

  // Unsigned add-and-clamp at the default widths; returns {sum, ovf}.
  function automatic logic [MAC_ACC_W:0] sat_add(input logic [MAC_ACC_W-1:0] acc,
                                                 input logic [MAC_PW-1:0]    prod);
    logic [MAC_ACC_W:0] raw;
    raw = {1'b0, acc} + {{(MAC_ACC_W + 1 - MAC_PW){1'b0}}, prod};
    if (raw[MAC_ACC_W]) begin
      sat_add = {{MAC_ACC_W{1'b1}}, 1'b1};
    end else begin
      sat_add = {raw[MAC_ACC_W-1:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/sat_add_unsigned.sv
// Combinational unsigned add with clamp to all-ones; ovf flags a clamp.
module sat_add_unsigned #(
  parameter int ACC_W = 24,
  parameter int PW    = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [PW-1:0]    prod_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] raw;

  // One extra bit catches the carry out; a set carry means the true sum is unrepresentable.
  always_comb begin
    raw   = {1'b0, acc_i} + {{(ACC_W + 1 - PW){1'b0}}, prod_i};
    ovf_o = raw[ACC_W];
    sum_o = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_accum_stream.sv
// Streaming saturating accumulator: sums product beats into frames and holds
// each closed frame's sum, count and flags until the consumer takes it.
//
//   state | meaning
//   ACC   | collecting beats, in_ready high once out of reset
//   HOLD  | closed frame presented on out_*, input stalled
module mac_accum_stream
  import mac_pkg::*;
#(
  parameter int PW        = MAC_PW,
  parameter int ACC_W     = MAC_ACC_W,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_trunc_q, out_trunc_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic             at_limit;

  sat_add_unsigned #(
    .ACC_W (ACC_W),
    .PW    (PW)
  ) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (in_prod),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  // in_ready_q is only ever high in ACC, so it alone qualifies acceptance.
  assign accept   = in_valid && in_ready_q;
  assign at_limit = (cnt_q == CNT_W'(MAX_TERMS - 1));

  // Next-state and datapath: clr overrides everything, then the per-state behaviour.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;

    if (clr) begin
      state_d     = ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ACC: begin
          in_ready_d = 1'b1;
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
            if (in_last || at_limit) begin
              out_sum_d   = add_sum;
              out_count_d = cnt_q + CNT_W'(1);
              out_ovf_d   = ovf_q | add_ovf;
              out_trunc_d = !in_last;
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ACC;
          end
        end
        default: begin
          state_d    = ACC;
          in_ready_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset leaves in_ready low until the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_mac_accum_stream.sv
// Bench for mac_accum_stream: default, 17-bit accumulator and 4-term instances,
// one active at a time, checked through a shared expected-result queue.
module tb_mac_accum_stream;

  typedef struct {
    logic [23:0] sum;
    int          cnt;
    logic        ovf;
    logic        trunc;
  } res_t;

  logic clk;
  logic rst_n;
  logic clr[3];
  logic in_valid[3];
  logic in_last[3];
  logic out_ready[3];
  logic [15:0] prod[3];
  logic rdy[3];
  logic ov[3];
  logic oovf[3];
  logic otr[3];
  logic [23:0] osum[3];
  logic [8:0]  ocnt[3];

  logic [23:0] sum0;
  logic [16:0] sum1;
  logic [23:0] sum2;
  logic [8:0]  cnt0;
  logic [8:0]  cnt1;
  logic [2:0]  cnt2;

  res_t   exp_q[$];
  longint m_acc[3];
  int     m_cnt[3];
  logic   m_ovf[3];
  int     n_chk;
  int     n_fail;

  mac_accum_stream u_def (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(rdy[0]),
    .in_prod(prod[0]), .in_last(in_last[0]), .out_valid(ov[0]), .out_ready(out_ready[0]),
    .out_sum(sum0), .out_count(cnt0), .out_ovf(oovf[0]), .out_trunc(otr[0])
  );

  mac_accum_stream #(.ACC_W(17)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(rdy[1]),
    .in_prod(prod[1]), .in_last(in_last[1]), .out_valid(ov[1]), .out_ready(out_ready[1]),
    .out_sum(sum1), .out_count(cnt1), .out_ovf(oovf[1]), .out_trunc(otr[1])
  );

  mac_accum_stream #(.MAX_TERMS(4)) u_trn (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(rdy[2]),
    .in_prod(prod[2]), .in_last(in_last[2]), .out_valid(ov[2]), .out_ready(out_ready[2]),
    .out_sum(sum2), .out_count(cnt2), .out_ovf(oovf[2]), .out_trunc(otr[2])
  );

  always_comb begin
    osum[0] = sum0;
    osum[1] = {7'd0, sum1};
    osum[2] = sum2;
    ocnt[0] = cnt0;
    ocnt[1] = cnt1;
    ocnt[2] = {6'd0, cnt2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: unsigned accumulate clamped at the instance's width.
  task automatic model_add(input int k, input logic [15:0] p, input logic l);
    longint mx;
    int     mt;
    res_t   e;
    mx = (k == 1) ? 64'h1FFFF : 64'hFFFFFF;
    mt = (k == 2) ? 4 : 256;
    m_acc[k] = m_acc[k] + longint'(p);
    if (m_acc[k] > mx) begin
      m_acc[k] = mx;
      m_ovf[k] = 1'b1;
    end
    m_cnt[k]++;
    if (l || m_cnt[k] == mt) begin
      e.sum   = 24'(m_acc[k]);
      e.cnt   = m_cnt[k];
      e.ovf   = m_ovf[k];
      e.trunc = !l;
      exp_q.push_back(e);
      model_clear(k);
    end
  endtask

  task automatic model_clear(input int k);
    m_acc[k] = 0;
    m_cnt[k] = 0;
    m_ovf[k] = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic beat(input int k, input logic [15:0] p, input logic l);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    prod[k]     = p;
    in_last[k]  = l;
    while (!rdy[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[k]) begin
      chk_eq("beat_timeout", 32'(rdy[k]), 1);
    end else begin
      model_add(k, p, l);
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  // Output scoreboard: every completed output handshake must match the oldest expected frame.
  always @(negedge clk) begin : sb_mon
    res_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && ov[k] && out_ready[k] && !clr[k]) begin
        if (exp_q.size() == 0) begin
          chk_eq("sb_underflow", 32'(ov[k]), 0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("sb_sum",   32'(osum[k]), 32'(e.sum));
          chk_eq("sb_count", 32'(ocnt[k]), 32'(e.cnt));
          chk_eq("sb_ovf",   32'(oovf[k]), 32'(e.ovf));
          chk_eq("sb_trunc", 32'(otr[k]),  32'(e.trunc));
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0; in_valid[k] = 1'b0; in_last[k] = 1'b0;
      out_ready[k] = 1'b0; prod[k] = '0;
      model_clear(k);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_eq("rst_ready", 32'(rdy[k]), 0);
      chk_eq("rst_valid", 32'(ov[k]), 0);
      chk_eq("rst_sum",   32'(osum[k]), 0);
      chk_eq("rst_count", 32'(ocnt[k]), 0);
    end
    rst_n = 1'b1;
    #1 chk_eq("ready_before_edge", 32'(rdy[0]), 0);
    @(posedge clk); #1;
    chk_eq("ready_after_release", 32'(rdy[0]), 1);

    // Basic frame with one-cycle output latency and a 1-cycle bubble.
    out_ready[0] = 1'b1;
    beat(0, 16'hFE01, 1'b0);
    beat(0, 16'h0001, 1'b0);
    chk_eq("basic_no_early_valid", 32'(ov[0]), 0);
    beat(0, 16'h0010, 1'b1);
    chk_eq("basic_valid", 32'(ov[0]), 1);
    chk_eq("basic_sum", 32'(osum[0]), 32'h00FE12);
    chk_eq("basic_count", 32'(ocnt[0]), 3);
    chk_eq("basic_ovf", 32'(oovf[0]), 0);
    chk_eq("basic_trunc", 32'(otr[0]), 0);
    chk_eq("basic_ready_low", 32'(rdy[0]), 0);
    @(posedge clk); #1;
    chk_eq("basic_valid_drop", 32'(ov[0]), 0);
    chk_eq("basic_ready_back", 32'(rdy[0]), 1);

    // Backpressure: outputs frozen while in_valid toggles.
    out_ready[0] = 1'b0;
    beat(0, 16'h0003, 1'b0);
    beat(0, 16'h0004, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = (i % 2) == 0;
      prod[0]     = 16'h1234;
      in_last[0]  = 1'b1;
      @(posedge clk); #1;
      chk_eq("bp_valid", 32'(ov[0]), 1);
      chk_eq("bp_sum", 32'(osum[0]), 7);
      chk_eq("bp_count", 32'(ocnt[0]), 2);
      chk_eq("bp_ready", 32'(rdy[0]), 0);
    end
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk_eq("bp_valid_drop", 32'(ov[0]), 0);
    chk_eq("bp_ready_back", 32'(rdy[0]), 1);
    beat(0, 16'h0009, 1'b1);
    chk_eq("bp_next_from_zero", 32'(osum[0]), 9);
    chk_eq("bp_next_count", 32'(ocnt[0]), 1);
    @(posedge clk); #1;

    // Saturation on a 17-bit accumulator.
    out_ready[1] = 1'b1;
    beat(1, 16'hFE01, 1'b0);
    beat(1, 16'hFE01, 1'b0);
    chk_eq("sat_acc_two", 32'(u_sat.acc_q), 32'h1FC02);
    beat(1, 16'hFE01, 1'b1);
    chk_eq("sat_sum", 32'(osum[1]), 32'h1FFFF);
    chk_eq("sat_ovf", 32'(oovf[1]), 1);
    chk_eq("sat_count", 32'(ocnt[1]), 3);
    @(posedge clk); #1;

    // Truncation at MAX_TERMS = 4, fifth beat lands in the next frame.
    out_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) beat(2, 16'h0001, 1'b0);
    chk_eq("trn_valid", 32'(ov[2]), 1);
    chk_eq("trn_sum", 32'(osum[2]), 4);
    chk_eq("trn_count", 32'(ocnt[2]), 4);
    chk_eq("trn_flag", 32'(otr[2]), 1);
    beat(2, 16'h0001, 1'b0);
    beat(2, 16'h0002, 1'b1);
    chk_eq("trn_f2_sum", 32'(osum[2]), 3);
    chk_eq("trn_f2_count", 32'(ocnt[2]), 2);
    chk_eq("trn_f2_flag", 32'(otr[2]), 0);
    @(posedge clk); #1;

    // Abort mid-frame; a beat presented with clr is dropped.
    beat(0, 16'h0007, 1'b0);
    beat(0, 16'h0008, 1'b0);
    clr[0] = 1'b1; in_valid[0] = 1'b1; prod[0] = 16'h0055;
    @(posedge clk); #1;
    clr[0] = 1'b0; in_valid[0] = 1'b0;
    model_clear(0);
    beat(0, 16'h0005, 1'b1);
    chk_eq("abort_sum", 32'(osum[0]), 5);
    chk_eq("abort_count", 32'(ocnt[0]), 1);
    @(posedge clk); #1;

    // clr during HOLD with out_ready high discards the held result.
    out_ready[0] = 1'b0;
    beat(0, 16'h0006, 1'b1);
    chk_eq("hold_clr_pre", 32'(ov[0]), 1);
    out_ready[0] = 1'b1;
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    chk_eq("hold_clr_valid", 32'(ov[0]), 0);
    chk_eq("hold_clr_ready", 32'(rdy[0]), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    beat(0, 16'h0011, 1'b1);
    chk_eq("after_clr_sum", 32'(osum[0]), 32'h11);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame drops everything at once.
    beat(0, 16'h0020, 1'b0);
    beat(0, 16'h0030, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", 32'(ov[0]), 0);
    chk_eq("arst_ready", 32'(rdy[0]), 0);
    chk_eq("arst_sum", 32'(osum[0]), 0);
    chk_eq("arst_count", 32'(ocnt[0]), 0);
    model_clear(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("arst_ready_back", 32'(rdy[0]), 1);
    beat(0, 16'h0040, 1'b1);
    chk_eq("arst_fresh_sum", 32'(osum[0]), 32'h40);
    chk_eq("arst_fresh_count", 32'(ocnt[0]), 1);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("sb_leftover", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
